// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, constants and the fetch buffer entry type
package riscv_pkg;
  localparam int INSTR_W = 32;
  localparam int XLEN = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: pointer/count FIFO with synchronous flush; head read straight from storage
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner feeding a combinational instruction ROM, buffering words toward decode
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc
);
  logic [XLEN-1:0] pc;
  logic full, empty, pop, push;
  fetch_entry_t entry_in, head;
  assign pop = out_valid & out_ready;
  assign push = fetch_en & ~redirect_valid & (~full | pop);
  assign entry_in = '{pc: pc, instr: imem_instr};
  assign imem_addr = pc;
  assign out_valid = ~empty;
  assign out_instr = empty ? NOP_INSTR : head.instr;
  assign out_pc = empty ? '0 : head.pc;
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din(entry_in),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk)
    if (rst) pc <= RESET_PC;
    else if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (push) pc <= pc + PC_STEP;
endmodule
